reg_file_move: RTL

// - Clocked, parametrised register file with one host write port, one registered read port
//   and a built-in register-to-register move engine (src -> dst copy without host round trip).
// - Next generation of the team's 32x8 register memory: width/depth generic, synchronous, handshaked move.
// - Sits between the control sequencer and datapath as the general-purpose register bank.

---
 rtl/reg_file_move.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/reg_file_move.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_move
// Register file: host write port, registered read port, src->dst move engine.
// Optional feature macro: PARITY_EN (per-entry even parity, error injection).
// Revision : 1.0
// ============================================================================
module reg_file_move #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = (1 << ADDR_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              mv_start_i,
    input  logic [ADDR_W-1:0] mv_src_i,
    input  logic [ADDR_W-1:0] mv_dst_i,
    output logic              mv_busy_o,
    output logic              mv_done_o,
    output logic              addr_err_o,
    input  logic              err_inj_i,
    output logic              par_err_o
);

`ifdef PARITY_EN
    localparam int c_ENT_W = DATA_W + 1;
`else
    localparam int c_ENT_W = DATA_W;
`endif
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_STORE = 2'd2
    } state_t;

    logic [c_ENT_W-1:0] mem_q [DEPTH];
    state_t             state_q;
    logic [ADDR_W-1:0]  src_q;
    logic [ADDR_W-1:0]  dst_q;
    logic [c_ENT_W-1:0] hold_q;
    logic               busy_q;
    logic               done_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic               rd_valid_q;
    logic               addr_err_q;

    logic               w_wr_ok;
    logic               w_rd_in;
    logic               w_src_in;
    logic               w_dst_in;
    logic               w_mv_err;
    logic [c_ENT_W-1:0] w_wr_word;
    logic [c_ENT_W-1:0] w_rd_word;
    logic [c_ENT_W-1:0] w_src_word;

    assign w_wr_ok  = wr_en_i && ({1'b0, wr_addr_i} < c_DEPTH);
    assign w_rd_in  = {1'b0, rd_addr_i} < c_DEPTH;
    assign w_src_in = {1'b0, mv_src_i} < c_DEPTH;
    assign w_dst_in = {1'b0, mv_dst_i} < c_DEPTH;
    assign w_mv_err = (state_q == ST_IDLE) && mv_start_i && !(w_src_in && w_dst_in);

`ifdef PARITY_EN
    // Stored bit makes the whole entry even; err_inj deliberately breaks that.
    assign w_wr_word = {(^wr_data_i) ^ err_inj_i, wr_data_i};
`else
    logic w_unused_inj;
    assign w_wr_word    = wr_data_i;
    assign w_unused_inj = err_inj_i;
`endif

    // Reads see the value the entry holds after this edge's writes.
    always_comb begin
        w_rd_word = mem_q[rd_addr_i];
        if (w_wr_ok && (wr_addr_i == rd_addr_i)) begin
            w_rd_word = w_wr_word;
        end else if ((state_q == ST_STORE) && (dst_q == rd_addr_i)) begin
            w_rd_word = hold_q;
        end
    end

    always_comb begin
        w_src_word = mem_q[src_q];
        if (w_wr_ok && (wr_addr_i == src_q)) begin
            w_src_word = w_wr_word;
        end
    end

    // Host write is ordered after the move store so it wins on a dst collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (state_q == ST_STORE) begin
                mem_q[dst_q] <= hold_q;
            end
            if (w_wr_ok) begin
                mem_q[wr_addr_i] <= w_wr_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mv_start_i) begin
                        src_q <= mv_src_i;
                        dst_q <= mv_dst_i;
                        if (w_src_in && w_dst_in) begin
                            state_q <= ST_FETCH;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    hold_q  <= w_src_word;
                    state_q <= ST_STORE;
                end
                ST_STORE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_data_q <= w_rd_in ? w_rd_word[DATA_W-1:0] : '0;
            end
            addr_err_q <= (wr_en_i && !w_wr_ok) || (rd_en_i && !w_rd_in) || w_mv_err;
        end
    end

`ifdef PARITY_EN
    logic par_err_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= rd_en_i && w_rd_in && (^w_rd_word);
        end
    end
    assign par_err_o = par_err_q;
`else
    assign par_err_o = 1'b0;
`endif

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign mv_busy_o  = busy_q;
    assign mv_done_o  = done_q;
    assign addr_err_o = addr_err_q;

endmodule
`default_nettype wire
